// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences the shared datapath.
// Optional retired-instruction counter enabled by MULTICYCLE_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int unsigned RESET_STATE_TRAP = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        trap,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_UPPER,
    S_TRAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_is_load;
  logic w_is_store;
  logic w_is_r;
  logic w_is_i;
  logic w_is_br;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_is_lui;
  logic w_is_auipc;
  logic w_taken;
  logic w_unused;

  assign w_is_load  = (op == OP_LOAD);
  assign w_is_store = (op == OP_STORE);
  assign w_is_r     = (op == OP_R);
  assign w_is_i     = (op == OP_I);
  assign w_is_br    = (op == OP_BR);
  assign w_is_jal   = (op == OP_JAL);
  assign w_is_jalr  = (op == OP_JALR);
  assign w_is_lui   = (op == OP_LUI);
  assign w_is_auipc = (op == OP_AUIPC);

  // funct7b5 belongs to the ALU decoder; the FSM never looks at it.
  assign w_unused = funct7b5;

  // BEQ/BNE only; every other funct3 falls through as not taken.
  assign w_taken = ((funct3 == 3'b000) & zero) |
                   ((funct3 == 3'b001) & ~zero);

  // Immediate type follows the opcode alone, whatever the state.
  always_comb begin
    imm_src = 3'b000;
    unique case (1'b1)
      w_is_load, w_is_i, w_is_jalr: imm_src = 3'b000;
      w_is_store:                   imm_src = 3'b001;
      w_is_br:                      imm_src = 3'b010;
      w_is_jal:                     imm_src = 3'b011;
      w_is_lui, w_is_auipc:         imm_src = 3'b100;
      default:                      imm_src = 3'b000;
    endcase
  end

  // State register; reset lands in FETCH so the fetch restarts at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-state datapath controls.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    trap       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        unique case (1'b1)
          w_is_load, w_is_store: w_next = S_MEMADR;
          w_is_r:                w_next = S_EXECR;
          w_is_i:                w_next = S_EXECI;
          w_is_br:               w_next = S_BRANCH;
          w_is_jal:              w_next = S_JAL;
          w_is_jalr:             w_next = S_JALR;
          w_is_lui, w_is_auipc:  w_next = S_UPPER;
          default: begin
            w_next = (RESET_STATE_TRAP != 0) ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = 2'b01;
        result_src = 2'b00;
        pc_write   = w_taken;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
        w_next     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        w_next    = S_JAL;
      end
      S_UPPER: begin
        alu_src_a = w_is_auipc ? 2'b01 : 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b00;
        w_next    = S_ALUWB;
      end
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic        w_retire;
  logic [31:0] r_retired;

  assign w_retire = (w_next == S_FETCH) &
                    ((r_state == S_MEMWB) |
                     (r_state == S_ALUWB) |
                     (r_state == S_BRANCH) |
                     ((r_state == S_MEMWRITE) & mem_ready));

  // Count completed instructions; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle lists plus
// random instruction streams, checking a NOP-skip and a trapping instance.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       regw;
    logic [2:0] imm;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] rs;
    logic       trap;
  } outs_t;

  typedef struct {
    logic  rdy;
    logic  zr;
    outs_t exp;
    string nm;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] imm;
  } imm_vec_t;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RR    = 7'b0110011;
  localparam logic [6:0] RI    = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b1111111;
  localparam logic [6:0] FENCE = 7'b0001111;

  logic clk;
  logic reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic zero;
  logic mem_ready;

  logic a_mreq, a_mwr, a_adr, a_irw, a_pcw, a_regw, a_trap;
  logic [2:0] a_imm;
  logic [1:0] a_asa, a_asb, a_aop, a_rs;
  logic [31:0] a_ret;
  logic b_mreq, b_mwr, b_adr, b_irw, b_pcw, b_regw, b_trap;
  logic [2:0] b_imm;
  logic [1:0] b_asa, b_asb, b_aop, b_rs;
  logic [31:0] b_ret;

  int total = 0;
  int bad = 0;
  logic [31:0] cnt = 32'd0;
  bit b_live = 1'b1;
  vec_t sq[$];

  multicycle_ctrl #(.RESET_STATE_TRAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mreq), .mem_write(a_mwr), .adr_src(a_adr),
    .ir_write(a_irw), .pc_write(a_pcw), .reg_write(a_regw),
    .imm_src(a_imm), .alu_src_a(a_asa), .alu_src_b(a_asb),
    .alu_op(a_aop), .result_src(a_rs), .trap(a_trap), .retired(a_ret)
  );

  multicycle_ctrl #(.RESET_STATE_TRAP(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mreq), .mem_write(b_mwr), .adr_src(b_adr),
    .ir_write(b_irw), .pc_write(b_pcw), .reg_write(b_regw),
    .imm_src(b_imm), .alu_src_a(b_asa), .alu_src_b(b_asb),
    .alu_op(b_aop), .result_src(b_rs), .trap(b_trap), .retired(b_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      LW, RI, JALR: return 3'b000;
      SW:           return 3'b001;
      BR:           return 3'b010;
      JAL:          return 3'b011;
      LUI, AUIPC:   return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

  // f = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
  function automatic outs_t mk(input logic [6:0] o, input logic [5:0] f,
                               input logic [1:0] asa, input logic [1:0] asb,
                               input logic [1:0] aop, input logic [1:0] rs);
    outs_t r;
    r = {f, imm_of(o), asa, asb, aop, rs, 1'b0};
    return r;
  endfunction

  function automatic outs_t fetch_wait(input logic [6:0] o);
    return mk(o, 6'b100000, 2'd0, 2'd2, 2'd0, 2'd2);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] exp_ret();
`ifdef MULTICYCLE_RETIRE_CNT_EN
    return cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic outs_t cur(input bit b);
    outs_t r;
    if (b)
      r = {b_mreq, b_mwr, b_adr, b_irw, b_pcw, b_regw, b_imm,
           b_asa, b_asb, b_aop, b_rs, b_trap};
    else
      r = {a_mreq, a_mwr, a_adr, a_irw, a_pcw, a_regw, a_imm,
           a_asa, a_asb, a_aop, a_rs, a_trap};
    return r;
  endfunction

  task automatic chk_one(input string nm, input bit b, input outs_t e);
    outs_t ac;
    logic [31:0] rr;
    ac = cur(b);
    rr = b ? b_ret : a_ret;
    total++;
    if (ac !== e) begin
      bad++;
      $display("FAIL %s dut%s outputs got=%h want=%h op=%b", nm,
               b ? "B" : "A", ac, e, op);
    end
    total++;
    if (rr !== exp_ret()) begin
      bad++;
      $display("FAIL %s_retired dut%s got=%0d want=%0d", nm,
               b ? "B" : "A", rr, exp_ret());
    end
  endtask

  task automatic chk(input string nm, input outs_t e);
    chk_one(nm, 1'b0, e);
    if (b_live) chk_one(nm, 1'b1, e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from fetch on.
  function automatic bit build(input logic [6:0] o, input logic [2:0] f3,
                               input logic z, input int fw, input int mw);
    bit legal;
    logic tk;
    outs_t aluwb;
    legal = 1'b1;
    sq = {};
    aluwb = mk(o, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < fw; i++)
      sq.push_back('{1'b0, rb(), fetch_wait(o), "fetch_wait"});
    sq.push_back('{1'b1, rb(),
      mk(o, 6'b100110, 2'd0, 2'd2, 2'd0, 2'd2), "fetch_go"});
    sq.push_back('{rb(), rb(),
      mk(o, 6'b000000, 2'd1, 2'd1, 2'd0, 2'd0), "decode"});
    case (o)
      LW, SW: begin
        sq.push_back('{rb(), rb(),
          mk(o, 6'b000000, 2'd2, 2'd1, 2'd0, 2'd0), "memadr"});
        for (int i = 0; i <= mw; i++)
          sq.push_back('{(i == mw), rb(),
            mk(o, (o == SW) ? 6'b111000 : 6'b101000,
               2'd0, 2'd0, 2'd0, 2'd0),
            (o == SW) ? "memwrite" : "memread"});
        if (o == LW)
          sq.push_back('{rb(), rb(),
            mk(o, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd1), "memwb"});
      end
      RR, RI: begin
        sq.push_back('{rb(), rb(),
          mk(o, 6'b000000, 2'd2, (o == RI) ? 2'd1 : 2'd0, 2'd2, 2'd0),
          "exec"});
        sq.push_back('{rb(), rb(), aluwb, "aluwb"});
      end
      BR: begin
        tk = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
        sq.push_back('{rb(), z,
          mk(o, {4'b0000, tk, 1'b0}, 2'd2, 2'd0, 2'd1, 2'd0), "branch"});
      end
      JAL, JALR: begin
        if (o == JALR)
          sq.push_back('{rb(), rb(),
            mk(o, 6'b000000, 2'd2, 2'd1, 2'd0, 2'd0), "jalr"});
        sq.push_back('{rb(), rb(),
          mk(o, 6'b000010, 2'd1, 2'd2, 2'd0, 2'd0), "jal"});
        sq.push_back('{rb(), rb(), aluwb, "aluwb"});
      end
      LUI, AUIPC: begin
        sq.push_back('{rb(), rb(),
          mk(o, 6'b000000, (o == AUIPC) ? 2'd1 : 2'd2, 2'd1, 2'd0, 2'd0),
          "upper"});
        sq.push_back('{rb(), rb(), aluwb, "aluwb"});
      end
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  task automatic apply(input int n, input logic [6:0] o,
                       input logic [2:0] f3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op = o;
      funct3 = f3;
      funct7b5 = rb();
      mem_ready = sq[i].rdy;
      zero = sq[i].zr;
      #1;
      chk(sq[i].nm, sq[i].exp);
    end
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3,
                     input logic z, input int fw, input int mw);
    bit legal;
    legal = build(o, f3, z, fw, mw);
    apply(sq.size(), o, f3);
    if (legal) cnt = cnt + 32'd1;
    else b_live = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    cnt = 32'd0;
    b_live = 1'b1;
    chk("reset", fetch_wait(op));
    @(negedge clk);
    #1;
    chk("reset_hold", fetch_wait(op));
    reset_n = 1'b1;
  endtask

  imm_vec_t itab[11];
  logic [6:0] rops[11];
  outs_t tr;
  bit lg;

  initial begin
    reset_n = 1'b0;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    zero = 1'b0;
    mem_ready = 1'b0;

    itab[0]  = '{LW, 3'b000};
    itab[1]  = '{RI, 3'b000};
    itab[2]  = '{JALR, 3'b000};
    itab[3]  = '{SW, 3'b001};
    itab[4]  = '{BR, 3'b010};
    itab[5]  = '{JAL, 3'b011};
    itab[6]  = '{LUI, 3'b100};
    itab[7]  = '{AUIPC, 3'b100};
    itab[8]  = '{RR, 3'b000};
    itab[9]  = '{BAD, 3'b000};
    itab[10] = '{FENCE, 3'b000};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      op = itab[i].op;
      mem_ready = 1'b0;
      #1;
      total++;
      if (a_imm !== itab[i].imm || a_mreq !== 1'b1) begin
        bad++;
        $display("FAIL imm_table[%0d] got imm=%b req=%b want imm=%b req=1",
                 i, a_imm, a_mreq, itab[i].imm);
      end
    end

    run(LW, 3'd2, 1'b0, 3, 0);
    run(SW, 3'd2, 1'b0, 0, 2);
    run(BR, 3'd0, 1'b1, 0, 0);
    run(BR, 3'd0, 1'b0, 1, 0);
    run(BR, 3'd1, 1'b0, 0, 0);
    run(BR, 3'd1, 1'b1, 0, 0);
    run(BR, 3'd4, 1'b1, 0, 0);
    run(JAL, 3'd0, 1'b0, 0, 0);
    run(LUI, 3'd0, 1'b0, 0, 0);
    run(AUIPC, 3'd0, 1'b0, 0, 0);
    run(RR, 3'd0, 1'b0, 0, 0);
    run(RI, 3'd3, 1'b0, 2, 0);
    run(JALR, 3'd0, 1'b0, 0, 0);

    rops = '{LW, SW, RR, RI, BR, JAL, JALR, LUI, AUIPC, BAD, FENCE};
    for (int k = 0; k < 60; k++) begin
      run(rops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), rb(),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Illegal opcode: A skips it, B parks in TRAP until reset.
    do_reset();
    run(BAD, 3'd0, 1'b0, 1, 0);
    tr = mk(BAD, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0);
    tr.trap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = BAD;
      mem_ready = (i == 3);
      #1;
      chk_one("trap_hold", 1'b1, tr);
      if (i < 3) chk("after_bad_a", fetch_wait(BAD));
    end

    // Reset pulsed in the middle of a load's memory read.
    do_reset();
    run(RR, 3'd0, 1'b0, 0, 0);
    lg = build(LW, 3'd0, 1'b0, 0, 3);
    apply(5, LW, 3'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    cnt = 32'd0;
    chk("rst_mid_memread", fetch_wait(LW));
    @(negedge clk);
    #1;
    chk("rst_mid_hold", fetch_wait(LW));
    reset_n = 1'b1;
    run(SW, 3'd0, 1'b0, 1, 1);
    run(LW, 3'd0, 1'b0, 0, 0);

    $display("instructions completed in model: %0d (build %0d)", cnt, lg);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
